// File: rtl/enq_desc_sched_pkg.sv
// Shared types and limits for the enqueue descriptor scheduler.
// Optional statistics are enabled with ENQ_DESC_SCHED_STATS_EN.
package enq_desc_sched_pkg;

    localparam int ENQ_SRC_MAX    = 8;
    localparam int ENQ_STAT_NBITS = 16;

    typedef struct packed {
        logic [7:0]  src_id;
        logic [11:0] pkt_len;
        logic [11:0] buf_ptr;
    } enq_pkt_desc_type;

endpackage

// File: rtl/enq_desc_sched_if.sv
// Bundle of producer, FIFO and dequeue signals around enq_desc_sched.
// Handshakes: src_req/src_ack transfer when both are 1 in the same cycle; deq_valid/deq_ready
// transfer when both are 1 at a rising edge, and deq_valid never drops until that transfer.
interface enq_desc_sched_if #(
    parameter int NUM_SRC = 4
);
    import enq_desc_sched_pkg::*;

    localparam int PTR_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] src_req;
    enq_pkt_desc_type   src_desc [NUM_SRC];
    logic [NUM_SRC-1:0] src_ack;

    logic               fifo_wr;
    enq_pkt_desc_type   fifo_din;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_rd;
    enq_pkt_desc_type   fifo_dout;

    logic               deq_valid;
    enq_pkt_desc_type   deq_desc;
    logic               deq_ready;

    logic [1:0]         dbg_occ;
    logic               dbg_inflight;
    logic [PTR_W-1:0]   dbg_rr_ptr;

    modport slave (
        input  src_req, src_desc, fifo_full, fifo_empty, fifo_dout, deq_ready,
        output src_ack, fifo_wr, fifo_din, fifo_rd, deq_valid, deq_desc,
        output dbg_occ, dbg_inflight, dbg_rr_ptr
    );

    modport master (
        output src_req, src_desc, fifo_full, fifo_empty, fifo_dout, deq_ready,
        input  src_ack, fifo_wr, fifo_din, fifo_rd, deq_valid, deq_desc,
        input  dbg_occ, dbg_inflight, dbg_rr_ptr
    );

endinterface

// File: rtl/enq_desc_sched_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
module enq_desc_rr_arb #(
    parameter int  NUM_SRC = 4,
    localparam int PTR_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [PTR_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (int'(ptr_i) + i) % NUM_SRC;
            if (!found && req_i[idx[PTR_W-1:0]]) begin
                found     = 1'b1;
                gnt_idx_o = idx[PTR_W-1:0];
            end
        end
        if (found) gnt_o[gnt_idx_o] = 1'b1;
        gnt_vld_o = found;
    end

endmodule

// File: rtl/enq_desc_sched.sv
// Round-robin enqueue onto the descriptor FIFO and a 2-entry skid buffer on its read side.
// Per-source stall counters exist only when ENQ_DESC_SCHED_STATS_EN is defined.
module enq_desc_sched
    import enq_desc_sched_pkg::*;
#(
    parameter int  NUM_SRC     = 4,
    parameter int  DEPTH_NBITS = 12,
    localparam int PTR_W       = $clog2(NUM_SRC)
) (
    input  logic            clk,
    input  logic            rst_n,
    enq_desc_sched_if.slave bus
`ifdef ENQ_DESC_SCHED_STATS_EN
    ,
    output logic [NUM_SRC-1:0][ENQ_STAT_NBITS-1:0] stat_stall_o
`endif
);

    if (NUM_SRC < 2 || NUM_SRC > ENQ_SRC_MAX || DEPTH_NBITS < 1) begin : g_cfg_err
        $error("enq_desc_sched: unsupported NUM_SRC/DEPTH_NBITS");
    end

    // ---------------- write side ----------------
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0] arb_req, gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_vld;

    // Grants are held off while in reset so src_ack/fifo_wr show their reset values.
    assign arb_req = bus.src_req & {NUM_SRC{rst_n & ~bus.fifo_full}};

    enq_desc_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
        .req_i    (arb_req),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (gnt),
        .gnt_idx_o(gnt_idx),
        .gnt_vld_o(gnt_vld)
    );

    assign bus.src_ack  = gnt;
    assign bus.fifo_wr  = gnt_vld;
    assign bus.fifo_din = gnt_vld ? bus.src_desc[gnt_idx] : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) rr_ptr_d = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    // ---------------- read side ----------------
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q;
    logic             hd_q;
    enq_pkt_desc_type buf_q [2];
    logic             pop;
    logic [2:0]       load;
    logic             tail;

    assign pop  = (occ_q != 2'd0) & bus.deq_ready;
    assign load = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    // A capture only happens with occ<=1, so the tail never collides with a live entry.
    assign tail = hd_q ^ occ_q[0];

    assign bus.fifo_rd   = rst_n & ~bus.fifo_empty & (load < 3'd2);
    assign bus.deq_valid = (occ_q != 2'd0);
    assign bus.deq_desc  = buf_q[hd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            hd_q       <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= bus.fifo_rd;
            hd_q       <= hd_q ^ pop;
            if (inflight_q) buf_q[tail] <= bus.fifo_dout;
        end
    end

    assign bus.dbg_occ      = occ_q;
    assign bus.dbg_inflight = inflight_q;
    assign bus.dbg_rr_ptr   = rr_ptr_q;

`ifdef ENQ_DESC_SCHED_STATS_EN
    logic [NUM_SRC-1:0][ENQ_STAT_NBITS-1:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.src_req[i] && !gnt[i] && stat_q[i] != {ENQ_STAT_NBITS{1'b1}})
                    stat_q[i] <= stat_q[i] + ENQ_STAT_NBITS'(1);
            end
        end
    end

    assign stat_stall_o = stat_q;
`endif

endmodule

// File: tb/tb_enq_desc_sched.sv
// Directed bench for enq_desc_sched with a behavioural registered-read FIFO and an output scoreboard.
module tb_enq_desc_sched;
  import enq_desc_sched_pkg::*;

  localparam int NUM_SRC     = 4;
  localparam int DEPTH_NBITS = 4;
  localparam int FDEPTH      = 1 << DEPTH_NBITS;
  localparam int DW          = $bits(enq_pkt_desc_type);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enq_desc_sched_if #(.NUM_SRC(NUM_SRC)) bus ();

`ifdef ENQ_DESC_SCHED_STATS_EN
  logic [NUM_SRC-1:0][ENQ_STAT_NBITS-1:0] stat_stall;
`endif

  enq_desc_sched #(.NUM_SRC(NUM_SRC), .DEPTH_NBITS(DEPTH_NBITS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
`ifdef ENQ_DESC_SCHED_STATS_EN
    ,
    .stat_stall_o(stat_stall)
`endif
  );

  // ---------------- FIFO model (pfull at DEPTH-1, registered read) ----------------
  logic [DW-1:0] f_mem [FDEPTH];
  logic [DW-1:0] f_dout;
  int f_cnt, f_wp, f_rp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_cnt  <= 0;
      f_wp   <= 0;
      f_rp   <= 0;
      f_dout <= '0;
    end else begin
      if (bus.fifo_wr) begin
        f_mem[f_wp] <= bus.fifo_din;
        f_wp        <= (f_wp + 1) % FDEPTH;
      end
      if (bus.fifo_rd) begin
        f_dout <= f_mem[f_rp];
        f_rp   <= (f_rp + 1) % FDEPTH;
      end
      f_cnt <= f_cnt + int'(bus.fifo_wr) - int'(bus.fifo_rd);
    end
  end

  assign bus.fifo_full  = (f_cnt >= FDEPTH - 1);
  assign bus.fifo_empty = (f_cnt == 0);
  assign bus.fifo_dout  = enq_pkt_desc_type'(f_dout);

  // ---------------- bench state ----------------
  int src_left [NUM_SRC];
  int src_seq  [NUM_SRC];
  logic tog = 1'b0;
  logic [NUM_SRC-1:0] ack_seen = '0;
  logic [DW-1:0] exp_q [$];
  int grant_log [$];
  int n_acc = 0;
  int n_out = 0;
  int m_ptr = 0;
  int g;
  logic [NUM_SRC-1:0] exp_ack;
  logic [DW-1:0] exp_d;

  function automatic enq_pkt_desc_type mk(int s, int q);
    enq_pkt_desc_type d;
    d.src_id  = 8'(s);
    d.pkt_len = 12'(q);
    d.buf_ptr = 12'(q * 5 + s + 1);
    return d;
  endfunction

  function automatic logic all_done();
    logic r;
    r = (exp_q.size() == 0);
    for (int i = 0; i < NUM_SRC; i++) if (src_left[i] != 0) r = 1'b0;
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr    = 0;
      ack_seen = '0;
      exp_q.delete();
    end else begin
      g = -1;
      if (!bus.fifo_full) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (g < 0 && bus.src_req[(m_ptr + i) % NUM_SRC]) g = (m_ptr + i) % NUM_SRC;
        end
      end
      exp_ack = '0;
      if (g >= 0) exp_ack[g] = 1'b1;
      chk("src_ack", bus.src_ack, exp_ack);
      chk("fifo_wr", bus.fifo_wr, (g >= 0));
      if (g >= 0) begin
        chk("fifo_din", bus.fifo_din, bus.src_desc[g]);
        exp_q.push_back(bus.src_desc[g]);
        m_ptr = (g + 1) % NUM_SRC;
      end
      if (bus.src_ack != '0) begin
        n_acc++;
        for (int i = 0; i < NUM_SRC; i++) if (bus.src_ack[i]) grant_log.push_back(i);
      end
      ack_seen = bus.src_ack;
      if (bus.deq_valid && bus.deq_ready) begin
        if (exp_q.size() == 0) chk("deq_extra", bus.deq_valid, 1'b0);
        else begin
          exp_d = exp_q.pop_front();
          chk("deq_desc", bus.deq_desc, exp_d);
          n_out++;
        end
      end
      chk("occ_max", (bus.dbg_occ <= 2'd2), 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_req[i]  = (src_left[i] > 0);
      bus.src_desc[i] = mk(i, src_seq[i]);
    end
    if (tog) bus.deq_ready = ~bus.deq_ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_seen[i] && src_left[i] > 0) begin
        src_seq[i]++;
        src_left[i]--;
      end
    end
    drive();
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) src_left[i] = 0;
    drive();
    step();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (all_done()) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(tag, ok, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  enq_pkt_desc_type e1, e5;
  logic ok;

  initial begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_left[i] = 0;
      src_seq[i]  = 0;
    end
    bus.deq_ready = 1'b1;
    do_reset();

    // reset state
    chk("rst_src_ack", bus.src_ack, 4'b0000);
    chk("rst_fifo_wr", bus.fifo_wr, 1'b0);
    chk("rst_fifo_rd", bus.fifo_rd, 1'b0);
    chk("rst_deq_valid", bus.deq_valid, 1'b0);
    chk("rst_deq_desc", bus.deq_desc, {DW{1'b0}});
    chk("rst_occ", bus.dbg_occ, 2'd0);
    chk("rst_inflight", bus.dbg_inflight, 1'b0);
    chk("rst_rr_ptr", bus.dbg_rr_ptr, 2'd0);

    // single descriptor latency (source 3, pointer wraps to 0)
    src_left[3] = 1;
    e1 = mk(3, src_seq[3]);
    drive();
    mid();
    chk("t1_ack_c0", bus.src_ack, 4'b1000);
    chk("t1_valid_c0", bus.deq_valid, 1'b0);
    step(); mid();
    chk("t1_rd_c1", bus.fifo_rd, 1'b1);
    chk("t1_valid_c1", bus.deq_valid, 1'b0);
    chk("t1_rr_wrap", bus.dbg_rr_ptr, 2'd0);
    step(); mid();
    chk("t1_inflight_c2", bus.dbg_inflight, 1'b1);
    chk("t1_valid_c2", bus.deq_valid, 1'b0);
    step(); mid();
    chk("t1_valid_c3", bus.deq_valid, 1'b1);
    chk("t1_desc_c3", bus.deq_desc, e1);
    step();
    drain("t1_drain", 20);

    // all four sources, 8 cycles of round robin
    grant_log.delete();
    for (int i = 0; i < NUM_SRC; i++) src_left[i] = 2;
    drive();
    for (int k = 0; k < 8; k++) begin
      mid();
      step();
    end
    chk("t2_grant_cnt", grant_log.size(), 8);
    for (int k = 0; k < 8; k++) chk("t2_grant_order", grant_log[k], exp_order[k]);
    drain("t2_drain", 40);

    // fill to full with the consumer stalled
    bus.deq_ready = 1'b0;
    n_acc = 0;
    src_left[0] = 40;
    drive();
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.fifo_full && bus.dbg_occ == 2'd2) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("t3_full_reached", ok, 1'b1);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("t3_full_ack", bus.src_ack, 4'b0000);
      chk("t3_full_rd", bus.fifo_rd, 1'b0);
      chk("t3_full_flag", bus.fifo_full, 1'b1);
      step();
    end
    chk("t3_accepted", n_acc, FDEPTH - 1 + 2);
    bus.deq_ready = 1'b1;
    mid();
    chk("t3_pop_rd", bus.fifo_rd, 1'b1);
    chk("t3_pop_ack", bus.src_ack, 4'b0000);
    step();
    bus.deq_ready = 1'b0;
    mid();
    chk("t3_reopen_full", bus.fifo_full, 1'b0);
    chk("t3_reopen_ack", bus.src_ack, 4'b0001);
    step(); mid();
    chk("t3_refull", bus.fifo_full, 1'b1);
    chk("t3_refull_ack", bus.src_ack, 4'b0000);
    step();
    bus.deq_ready = 1'b1;
    drain("t3_drain", 200);

    // 100 descriptors with deq_ready toggling every cycle
    n_out = 0;
    for (int i = 0; i < NUM_SRC; i++) src_left[i] = 25;
    tog = 1'b1;
    drive();
    drain("t4_drain", 1000);
    chk("t4_count", n_out, 100);
    tog = 1'b0;
    bus.deq_ready = 1'b1;

    // asynchronous reset with a read in flight and the buffer occupied
    src_left[0] = 10;
    drive();
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus.dbg_inflight && bus.dbg_occ != 2'd0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("t5_busy_reached", ok, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_arst_valid", bus.deq_valid, 1'b0);
    chk("t5_arst_desc", bus.deq_desc, {DW{1'b0}});
    chk("t5_arst_occ", bus.dbg_occ, 2'd0);
    chk("t5_arst_inflight", bus.dbg_inflight, 1'b0);
    chk("t5_arst_ack", bus.src_ack, 4'b0000);
    chk("t5_arst_wr", bus.fifo_wr, 1'b0);
    chk("t5_arst_rd", bus.fifo_rd, 1'b0);
    chk("t5_arst_ptr", bus.dbg_rr_ptr, 2'd0);
    do_reset();
    src_left[1] = 1;
    e5 = mk(1, src_seq[1]);
    drive();
    mid();
    chk("t5_post_ack", bus.src_ack, 4'b0010);
    step(); mid();
    step(); mid();
    step(); mid();
    chk("t5_post_valid", bus.deq_valid, 1'b1);
    chk("t5_post_desc", bus.deq_desc, e5);
    step();
    drain("t5_drain", 20);

`ifdef ENQ_DESC_SCHED_STATS_EN
    // stall counters: 5 blocked cycles, then saturation
    do_reset();
    bus.deq_ready = 1'b0;
    src_left[0] = 40;
    drive();
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.fifo_full && bus.dbg_occ == 2'd2) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("t6_full_reached", ok, 1'b1);
    chk("t6_stat2_zero", stat_stall[2], 16'd0);
    src_left[2] = 1;
    drive();
    repeat (5) step();
    chk("t6_stat2_five", stat_stall[2], 16'd5);
    chk("t6_stat1_idle", stat_stall[1], 16'd0);
    repeat (70000) @(posedge clk);
    #1;
    chk("t6_stat2_sat", stat_stall[2], 16'hFFFF);
    chk("t6_stat3_idle", stat_stall[3], 16'd0);
    bus.deq_ready = 1'b1;
    drive();
    drain("t6_drain", 200);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
